io_out_buffer: RTL and testbench

IO_OUT_BUFFER -- requirements
Module: io_out_buffer

---
 rtl/io_out_buffer_if.sv | 33 +++
 rtl/io_out_buffer.sv | 121 ++++++++++++
 tb/tb_io_out_buffer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/io_out_buffer_if.sv
// ============================================================================
// Module      : io_out_buffer_if
// Description : CPU write bus and host transmit handshake for io_out_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface io_out_buffer_if;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        overflow;
  logic        program_end;

  // Drives the buffer: CPU bus, host-side ready.
  modport master (
    output rdy_in, mem_a, mem_dout, mem_wr, tx_ready,
    input  io_buffer_full, tx_data, tx_valid, overflow, program_end
  );

  // The buffer itself.
  modport slave (
    input  rdy_in, mem_a, mem_dout, mem_wr, tx_ready,
    output io_buffer_full, tx_data, tx_valid, overflow, program_end
  );
endinterface

`default_nettype wire

// File: rtl/io_out_buffer.sv
// ============================================================================
// Module      : io_out_buffer
// Description : Memory-mapped byte output FIFO with halt/drain sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_out_buffer #(
  parameter int          DEPTH        = 16,
  parameter logic [31:0] IO_DATA_ADDR = 32'h0003_0000,
  parameter logic [31:0] IO_HALT_ADDR = 32'h0003_0004
) (
  input  logic          clk_in,
  input  logic          rst_in,
  io_out_buffer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]   c_depth    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_full_thr = (AW+1)'(DEPTH - 2);
  localparam logic [AW:0]   c_cnt_one  = (AW+1)'(1);
  localparam logic [AW-1:0] c_ptr_one  = AW'(1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        r_state;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic          r_overflow;
  logic          r_full;
  logic          r_program_end;
  logic [7:0]    r_mem [DEPTH];

  logic          w_data_wr;
  logic          w_halt_wr;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic [AW:0]   w_count_next;

  assign w_data_wr = bus.rdy_in && bus.mem_wr && (bus.mem_a == IO_DATA_ADDR) && (r_state == RUN);
  assign w_halt_wr = bus.rdy_in && bus.mem_wr && (bus.mem_a == IO_HALT_ADDR) && (r_state == RUN);
  assign w_pop     = (r_count != '0) && bus.tx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push    = w_data_wr && ((r_count != c_depth) || w_pop);
  assign w_drop    = w_data_wr && !w_push;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + c_cnt_one;
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - c_cnt_one;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= RUN;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_overflow    <= 1'b0;
      r_full        <= 1'b0;
      r_program_end <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_full  <= (w_count_next >= c_full_thr);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        RUN: begin
          if (w_halt_wr) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_count_next == '0) begin
            r_state       <= DONE;
            r_program_end <= 1'b1;
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by r_count.
  always_ff @(posedge clk_in) begin
    if (!rst_in && w_push) begin
      r_mem[r_wr_ptr] <= bus.mem_dout;
    end
  end

  assign bus.tx_valid       = (r_count != '0);
  assign bus.tx_data        = r_mem[r_rd_ptr];
  assign bus.io_buffer_full = r_full;
  assign bus.overflow       = r_overflow;
  assign bus.program_end    = r_program_end;

endmodule

`default_nettype wire

// File: tb/tb_io_out_buffer.sv
// ============================================================================
// Module      : tb_io_out_buffer
// Description : Directed self-checking bench for io_out_buffer (DEPTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_out_buffer;

  localparam logic [31:0] c_data_addr = 32'h0003_0000;
  localparam logic [31:0] c_halt_addr = 32'h0003_0004;
  localparam logic [31:0] c_st_run    = 32'd0;
  localparam logic [31:0] c_st_drain  = 32'd1;
  localparam logic [31:0] c_st_done   = 32'd2;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  io_out_buffer_if bus ();

  io_out_buffer #(
    .DEPTH        (16),
    .IO_DATA_ADDR (c_data_addr),
    .IO_HALT_ADDR (c_halt_addr)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [31:0] addr, input logic [7:0] data);
    bus.mem_wr   = wr;
    bus.mem_a    = addr;
    bus.mem_dout = data;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 32'd0, 8'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.rdy_in   = 1'b1;
    bus.tx_ready = 1'b0;
    drive(1'b0, 32'd0, 8'd0);
    do_reset();

    check("rst_valid",  32'(bus.tx_valid), 32'd0);
    check("rst_full",   32'(bus.io_buffer_full), 32'd0);
    check("rst_ovf",    32'(bus.overflow), 32'd0);
    check("rst_end",    32'(bus.program_end), 32'd0);
    check("rst_count",  32'(dut.r_count), 32'd0);
    check("rst_state",  32'(dut.r_state), c_st_run);

    // Two bytes streamed straight through.
    bus.tx_ready = 1'b1;
    drive(1'b1, c_data_addr, 8'h48);
    tick();
    check("h_valid", 32'(bus.tx_valid), 32'd1);
    check("h_data",  32'(bus.tx_data), 32'h48);
    drive(1'b1, c_data_addr, 8'h69);
    tick();
    check("i_data",  32'(bus.tx_data), 32'h69);
    check("i_count", 32'(dut.r_count), 32'd1);
    drive(1'b0, c_data_addr, 8'h00);
    tick();
    check("hi_empty", 32'(bus.tx_valid), 32'd0);

    // Ignored writes: CPU not ready, foreign address.
    bus.tx_ready = 1'b0;
    bus.rdy_in   = 1'b0;
    drive(1'b1, c_data_addr, 8'h01);
    tick();
    check("rdy_low_blk", 32'(dut.r_count), 32'd0);
    bus.rdy_in = 1'b1;
    drive(1'b1, 32'h0003_0008, 8'h02);
    tick();
    check("other_addr", 32'(dut.r_count), 32'd0);

    // Fill to full with the consumer stalled.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, c_data_addr, 8'h10 + 8'(i));
      tick();
      if (i == 12) check("full_at13", 32'(bus.io_buffer_full), 32'd0);
      if (i == 13) check("full_at14", 32'(bus.io_buffer_full), 32'd1);
    end
    check("cnt_16", 32'(dut.r_count), 32'd16);
    check("ovf_16", 32'(bus.overflow), 32'd0);

    // Full, push and pop together: both accepted.
    bus.tx_ready = 1'b1;
    drive(1'b1, c_data_addr, 8'hAA);
    tick();
    check("pp_count", 32'(dut.r_count), 32'd16);
    check("pp_ovf",   32'(bus.overflow), 32'd0);
    check("pp_head",  32'(bus.tx_data), 32'h11);

    // Full, push alone: dropped.
    bus.tx_ready = 1'b0;
    drive(1'b1, c_data_addr, 8'hEE);
    tick();
    check("drop_ovf",   32'(bus.overflow), 32'd1);
    check("drop_count", 32'(dut.r_count), 32'd16);
    check("drop_head",  32'(bus.tx_data), 32'h11);

    // Drain: 0x11..0x1F then 0xAA, with the CPU idle.
    drive(1'b0, 32'd0, 8'd0);
    bus.rdy_in   = 1'b0;
    bus.tx_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("drain%0d", k), 32'(bus.tx_data), (k < 15) ? 32'h11 + 32'(k) : 32'hAA);
      tick();
    end
    check("drain_empty", 32'(bus.tx_valid), 32'd0);
    check("drain_full",  32'(bus.io_buffer_full), 32'd0);
    bus.rdy_in = 1'b1;

    // Reset mid-operation discards queued bytes; reset beats a push.
    do_reset();
    check("ovf_clr", 32'(bus.overflow), 32'd0);
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, c_data_addr, 8'h60 + 8'(i));
      tick();
    end
    check("five_cnt", 32'(dut.r_count), 32'd5);
    rst = 1'b1;
    drive(1'b1, c_data_addr, 8'h99);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'd0, 8'd0);
    check("mrst_valid", 32'(bus.tx_valid), 32'd0);
    check("mrst_count", 32'(dut.r_count), 32'd0);
    check("mrst_state", 32'(dut.r_state), c_st_run);
    drive(1'b1, c_data_addr, 8'h5A);
    tick();
    check("mrst_new",  32'(bus.tx_data), 32'h5A);
    check("mrst_cnt1", 32'(dut.r_count), 32'd1);

    // Halt with three queued bytes, data write during drain is ignored.
    do_reset();
    bus.tx_ready = 1'b0;
    drive(1'b1, c_data_addr, 8'h31);
    tick();
    drive(1'b1, c_data_addr, 8'h32);
    tick();
    drive(1'b1, c_data_addr, 8'h33);
    tick();
    bus.tx_ready = 1'b1;
    drive(1'b1, c_halt_addr, 8'h00);
    tick();
    check("halt_state", 32'(dut.r_state), c_st_drain);
    check("halt_data",  32'(bus.tx_data), 32'h32);
    check("halt_end0",  32'(bus.program_end), 32'd0);
    bus.rdy_in = 1'b0;
    drive(1'b1, c_data_addr, 8'h77);
    tick();
    check("dr_count", 32'(dut.r_count), 32'd1);
    check("dr_data",  32'(bus.tx_data), 32'h33);
    check("dr_end0",  32'(bus.program_end), 32'd0);
    bus.rdy_in = 1'b1;
    drive(1'b1, c_data_addr, 8'h78);
    tick();
    check("done_end",   32'(bus.program_end), 32'd1);
    check("done_valid", 32'(bus.tx_valid), 32'd0);
    check("done_ovf",   32'(bus.overflow), 32'd0);
    drive(1'b1, c_data_addr, 8'h79);
    tick();
    drive(1'b1, c_halt_addr, 8'h00);
    tick();
    check("done_stay",  32'(dut.r_state), c_st_done);
    check("done_empty", 32'(bus.tx_valid), 32'd0);

    // Halt on an empty FIFO.
    do_reset();
    drive(1'b1, c_halt_addr, 8'h00);
    tick();
    drive(1'b0, 32'd0, 8'd0);
    check("eh_state1", 32'(dut.r_state), c_st_drain);
    tick();
    check("eh_state2", 32'(dut.r_state), c_st_done);
    check("eh_end",    32'(bus.program_end), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
